// File: rtl/ysyx_22040088_lsu_pkg.sv
// Shared definitions for the load/store unit.
// Contents: data/address width, FSM state encoding, mem_mask size codes,
// and two helpers that decode a size mask: legality/alignment and strobes.
package ysyx_22040088_lsu_pkg;

  localparam int XLEN = 64;

  // mem_mask is one-hot, with the widest access in the lowest bit
  localparam logic [3:0] MASK_D = 4'b0001;
  localparam logic [3:0] MASK_W = 4'b0010;
  localparam logic [3:0] MASK_H = 4'b0100;
  localparam logic [3:0] MASK_B = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_t;

  // 1 when the mask is not one-hot, or when the offset breaks natural alignment
  function automatic logic access_illegal(input logic [3:0] mask, input logic [2:0] off);
    logic bad;
    case (mask)
      MASK_D:  bad = (off != 3'd0);
      MASK_W:  bad = (off[1:0] != 2'd0);
      MASK_H:  bad = off[0];
      MASK_B:  bad = 1'b0;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Byte strobes for an access at offset 0
  function automatic logic [7:0] size_strb(input logic [3:0] mask);
    logic [7:0] s;
    case (mask)
      MASK_D:  s = 8'hFF;
      MASK_W:  s = 8'h0F;
      MASK_H:  s = 8'h03;
      MASK_B:  s = 8'h01;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ysyx_22040088_lsu_extend.sv
// Load-result alignment: shifts the aligned 8-byte bus word down to the
// addressed byte, truncates to the access size and sign/zero-extends.
// Ports:
//   rdata       in  aligned 8-byte read data
//   offset      in  byte offset inside the 8-byte word (addr[2:0])
//   mask        in  one-hot size code
//   is_unsigned in  1 = zero-extend, 0 = sign-extend (doubles never extend)
//   result      out extended load value
module ysyx_22040088_lsu_extend
  import ysyx_22040088_lsu_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      offset,
  input  logic [3:0]      mask,
  input  logic            is_unsigned,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] shifted;

  assign shifted = rdata >> {offset, 3'b000};

  always_comb begin
    result = shifted;
    case (mask)
      MASK_W: result = is_unsigned ? {32'b0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      MASK_H: result = is_unsigned ? {48'b0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      MASK_B: result = is_unsigned ? {56'b0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/ysyx_22040088_lsu.sv
// Load/store unit: accepts one memory operation from the core, issues a
// single aligned bus request, waits for the response and reports a
// one-cycle completion with the extended load data or an error flag.
//
// state | meaning
// IDLE  | waiting for in_valid & mem_ena
// REQ   | req_valid high, req_* held until req_ready
// WAIT  | request accepted, waiting for resp_valid
// DONE  | out_valid pulse, then back to IDLE
//
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   in_valid, mem_ena, mem_wen,       operation issue from the core
//   mem_mask, load_unsigned, addr, wdata
//   busy, out_valid, out_rdata, out_err   status / completion to the core
//   req_valid, req_ready, req_addr,   bus request channel
//   req_wen, req_wdata, req_wstrb
//   resp_valid, resp_rdata            bus response channel
module ysyx_22040088_lsu
  import ysyx_22040088_lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic            mem_ena,
  input  logic            mem_wen,
  input  logic [3:0]      mem_mask,
  input  logic            load_unsigned,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            out_valid,
  output logic [XLEN-1:0] out_rdata,
  output logic            out_err,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  output logic            req_wen,
  output logic [XLEN-1:0] req_wdata,
  output logic [7:0]      req_wstrb,
  input  logic            resp_valid,
  input  logic [XLEN-1:0] resp_rdata
);

  lsu_state_t      state;
  logic [2:0]      off_q;
  logic [3:0]      mask_q;
  logic            uns_q;
  logic            wen_q;
  logic [XLEN-1:0] ext_res;

  ysyx_22040088_lsu_extend u_extend (
    .rdata       (resp_rdata),
    .offset      (off_q),
    .mask        (mask_q),
    .is_unsigned (uns_q),
    .result      (ext_res)
  );

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      off_q     <= '0;
      mask_q    <= '0;
      uns_q     <= 1'b0;
      wen_q     <= 1'b0;
      out_valid <= 1'b0;
      out_err   <= 1'b0;
      out_rdata <= '0;
      req_valid <= 1'b0;
      req_addr  <= '0;
      req_wen   <= 1'b0;
      req_wdata <= '0;
      req_wstrb <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid && mem_ena) begin
            off_q  <= addr[2:0];
            mask_q <= mem_mask;
            uns_q  <= load_unsigned;
            wen_q  <= mem_wen;
            if (access_illegal(mem_mask, addr[2:0])) begin
              // Errors complete directly without touching the bus
              state     <= ST_DONE;
              out_valid <= 1'b1;
              out_err   <= 1'b1;
              out_rdata <= '0;
            end else begin
              state     <= ST_REQ;
              req_valid <= 1'b1;
              req_addr  <= {addr[XLEN-1:3], 3'b000};
              req_wen   <= mem_wen;
              req_wdata <= wdata << {addr[2:0], 3'b000};
              req_wstrb <= mem_wen ? (size_strb(mem_mask) << addr[2:0]) : 8'h00;
            end
          end
        end
        ST_REQ: begin
          // Any resp_valid in this cycle is ignored: responses count only in WAIT
          if (req_ready) begin
            req_valid <= 1'b0;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (resp_valid) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
            out_err   <= 1'b0;
            out_rdata <= wen_q ? '0 : ext_res;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/ysyx_22040088_lsu.md
YSYX_22040088_LSU -- requirements
Module: ysyx_22040088_lsu

Interface
REQ-001 Parameter: XLEN, 64, data and address width; the only supported value is 64.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  reset; asynchronous assertion, active-low.
REQ-004 in_valid  in  1  core issues one memory operation this cycle.
REQ-005 mem_ena  in  1  operation is a load or store; in_valid with mem_ena=0 is ignored.
REQ-006 mem_wen  in  1  1 = store, 0 = load.
REQ-007 mem_mask  in  4  one-hot size: 0001 = double (8B), 0010 = word, 0100 = half, 1000 = byte.
REQ-008 load_unsigned  in  1  zero-extend the load result; this is sel_rfres bit 2 from the control unit.
REQ-009 addr  in  XLEN  byte address.
REQ-010 wdata  in  XLEN  store data, right-justified.
REQ-011 busy  out  1  operation in flight; the core stalls while busy=1.
REQ-012 out_valid  out  1  one-cycle completion pulse.
REQ-013 out_rdata  out  XLEN  extended load result; 0 for stores and errors.
REQ-014 out_err  out  1  misaligned address or illegal mask; qualified by out_valid.
REQ-015 req_valid / req_ready  out / in  1 / 1  bus request handshake.
REQ-016 req_addr  out  XLEN  request address, 8-byte aligned ({addr[63:3], 3'b000}).
REQ-017 req_wen  out  1  store request.
REQ-018 req_wdata  out  XLEN  store data shifted left by addr[2:0]*8.
REQ-019 req_wstrb  out  8  byte strobes; 0 for loads.
REQ-020 resp_valid  in  1  bus response or write acknowledge.
REQ-021 resp_rdata  in  XLEN  aligned 8-byte read data.

Function
REQ-022 FSM states SHALL be IDLE, REQ, WAIT and DONE; busy = (state != IDLE).
REQ-023 In IDLE with in_valid & mem_ena, the block SHALL latch addr, wdata, mem_mask, mem_wen and load_unsigned.
REQ-024 After latching a legal operation, the block SHALL go to REQ; an illegal one goes to DONE with the error flagged.
REQ-025 Illegal SHALL mean mem_mask not one-hot, or addr not aligned to the access size (half: addr[0]; word: addr[1:0]; double: addr[2:0]).
REQ-026 In REQ, req_valid=1 and all req_* outputs SHALL hold stable until req_ready=1; then the FSM goes to WAIT.
REQ-027 req_wstrb SHALL be the size mask shifted left by addr[2:0]: byte 0x01, half 0x03, word 0x0F, double 0xFF.
REQ-028 In WAIT, resp_valid=1 SHALL capture the result and move the FSM to DONE.
REQ-029 For loads, the captured result SHALL be resp_rdata >> (addr[2:0]*8), truncated to the access size, then sign- or zero-extended per load_unsigned; doubles are never extended.
REQ-030 In DONE, out_valid=1 for exactly one cycle; the FSM then returns to IDLE.
REQ-031 Minimum latency, with req_ready and resp_valid both immediate: accept at cycle 0, req_valid at cycle 1, resp at cycle 2, out_valid at cycle 3.
REQ-032 An error completion SHALL assert out_valid one cycle after acceptance, with req_valid never asserted.
REQ-033 in_valid while busy=1 SHALL be ignored.
REQ-034 resp_valid outside WAIT SHALL be ignored.
REQ-035 A response arriving in the same cycle as req_ready SHALL NOT be accepted; responses count only in WAIT.
REQ-036 out_rdata and out_err SHALL hold their values until the next DONE.

Reset
REQ-037 On rst_n=0: state = IDLE; busy, out_valid, out_err, req_valid and req_wen = 0; req_wstrb = 0; out_rdata, req_addr and req_wdata = 0.
REQ-038 Reset asserted mid-operation SHALL drop req_valid immediately and abandon the operation; a late response after reset is ignored per REQ-034.

Structure
REQ-039 A shared package SHALL hold the FSM state encoding, the mem_mask size constants (MASK_D/W/H/B) and XLEN.
REQ-040 One combinational sub-module, ysyx_22040088_lsu_extend, SHALL perform shift/truncate/extend, taking (rdata, offset, mask, unsigned) and producing the result.

Verification
REQ-041 Load byte, addr 0x80000003, unsigned=0, resp_rdata 0x00000000_80000000 -> req_addr 0x80000000, out_rdata 0xFFFFFFFF_FFFFFF80.
REQ-042 Same stimulus with load_unsigned=1 -> out_rdata 0x00000000_00000080.
REQ-043 Store half, addr 0x80000006, wdata 0x1234 -> req_wstrb 0xC0, req_wdata 0x1234_0000_0000_0000, out_err=0.
REQ-044 Load word at addr 0x80000002 -> out_valid with out_err=1 one cycle later, req_valid never asserted.
REQ-045 req_ready held low 5 cycles -> req_* stable throughout, busy=1, a second in_valid during the stall is ignored.
REQ-046 rst_n pulsed low in WAIT, then resp_valid=1 -> no out_valid, state IDLE, busy=0.
